// File: rtl/axi_wr_pkg.sv
// Shared definitions for the AXI write master: FSM state encoding, AXI
// response codes and the default data-bus width.
package axi_wr_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 128;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    CAPTURE   = 3'd2,
    ADDR_DATA = 3'd3,
    RESP      = 3'd4
  } state_t;

endpackage

// File: rtl/axi_addr_gen.sv
// Circular DDR address generator: starts at BASE_ADDR and steps by
// STEP_BYTES on each advance, wrapping to BASE_ADDR after word REGION_WORDS-1.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (addr -> BASE_ADDR)
//   advance     - one-cycle pulse, move to the next word address
//   addr        - current word byte address (registered)
module axi_addr_gen #(
  parameter int unsigned             ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR    = '0,
  parameter int unsigned             REGION_WORDS = 256,
  parameter int unsigned             STEP_BYTES   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  advance,
  output logic [ADDR_WIDTH-1:0] addr
);

  localparam int unsigned IDX_W = (REGION_WORDS > 1) ? $clog2(REGION_WORDS) : 1;
  localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(REGION_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(STEP_BYTES);

  logic [IDX_W-1:0] idx;

  // Word index tracks position in the region so the wrap needs no address compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      addr <= BASE_ADDR;
    end else if (advance) begin
      if (idx == LAST_IDX) begin
        idx  <= '0;
        addr <= BASE_ADDR;
      end else begin
        idx  <= idx + IDX_W'(1);
        addr <= addr + STEP;
      end
    end
  end

endmodule

// File: rtl/axi_wr_master.sv
// Drains an upstream sync FIFO one word at a time into single-beat AXI
// writes over a circular DDR region.
// Optional feature: define AXI_WR_ERR_CNT_EN to add the err_count output.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   fifo_empty          - upstream FIFO empty flag
//   fifo_rd_en          - one-cycle read strobe per word
//   fifo_rd_data        - FIFO data, valid one cycle after fifo_rd_en
//   m_aw*, m_w*, m_b*   - AXI write address / data / response channels
//   wr_count            - completed B handshakes (wraps)
//   err_count           - non-OKAY responses, saturating (optional)
//   busy                - high whenever the FSM is not in IDLE
module axi_wr_master
  import axi_wr_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned           ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(32'h0000_0000),
  parameter int unsigned           REGION_WORDS = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    fifo_empty,
  output logic                    fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]   fifo_rd_data,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [15:0]             wr_count,
`ifdef AXI_WR_ERR_CNT_EN
  output logic [7:0]              err_count,
`endif
  output logic                    busy
);

  localparam int unsigned STEP_BYTES = DATA_WIDTH / 8;

  state_t                state_q, state_d;
  logic                  rd_en_d, awvalid_d, wvalid_d, bready_d;
  logic [DATA_WIDTH-1:0] wdata_d;
  logic                  advance_c;
  logic                  aw_done_c, w_done_c;

  assign m_wstrb = '1;

  // A channel counts as done once its valid has dropped or is being accepted now.
  assign aw_done_c = !m_awvalid || m_awready;
  assign w_done_c  = !m_wvalid  || m_wready;

  // Next-state and next-output logic; outputs are registered below.
  always_comb begin
    state_d   = state_q;
    rd_en_d   = 1'b0;
    awvalid_d = m_awvalid;
    wvalid_d  = m_wvalid;
    bready_d  = m_bready;
    wdata_d   = m_wdata;
    advance_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          rd_en_d = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        wdata_d   = fifo_rd_data;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        state_d   = ADDR_DATA;
      end
      ADDR_DATA: begin
        if (m_awvalid && m_awready) awvalid_d = 1'b0;
        if (m_wvalid && m_wready)   wvalid_d  = 1'b0;
        if (aw_done_c && w_done_c) begin
          bready_d = 1'b1;
          state_d  = RESP;
        end
      end
      RESP: begin
        if (m_bvalid) begin
          bready_d  = 1'b0;
          advance_c = 1'b1;
          state_d   = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      fifo_rd_en <= 1'b0;
      m_awvalid  <= 1'b0;
      m_wvalid   <= 1'b0;
      m_bready   <= 1'b0;
      m_wdata    <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      fifo_rd_en <= rd_en_d;
      m_awvalid  <= awvalid_d;
      m_wvalid   <= wvalid_d;
      m_bready   <= bready_d;
      m_wdata    <= wdata_d;
      busy       <= (state_d != IDLE);
    end
  end

  // Completed-write counter; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
    end else if (advance_c) begin
      wr_count <= wr_count + 16'd1;
    end
  end

`ifdef AXI_WR_ERR_CNT_EN
  // Saturating count of B handshakes carrying a non-OKAY response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (advance_c && (m_bresp != RESP_OKAY) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`else
  // Response code is only inspected by the error counter.
  logic unused_bresp;
  assign unused_bresp = ^m_bresp;
`endif

  axi_addr_gen #(
    .ADDR_WIDTH   (ADDR_WIDTH),
    .BASE_ADDR    (BASE_ADDR),
    .REGION_WORDS (REGION_WORDS),
    .STEP_BYTES   (STEP_BYTES)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .advance (advance_c),
    .addr    (m_awaddr)
  );

endmodule

// File: doc/axi_wr_master.md
AXI_WR_MASTER -- requirements
Module: axi_wr_master

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 128, width in bits of a packed FIFO word and of the AXI write data bus.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, width in bits of the AXI address.
REQ-003 SHALL have parameter BASE_ADDR, default 32'h0000_0000, byte address of the first DDR write.
REQ-004 SHALL have parameter REGION_WORDS, default 256, number of words in the circular DDR region.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is clocked on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port fifo_empty, input, 1, upstream sync FIFO empty flag.
REQ-008 SHALL have port fifo_rd_en, output, 1, FIFO read strobe; must be high for exactly one cycle per word.
REQ-009 SHALL have port fifo_rd_data, input, DATA_WIDTH, FIFO read data, valid one cycle after fifo_rd_en.
REQ-010 SHALL have port m_awaddr, output, ADDR_WIDTH, AXI write address.
REQ-011 SHALL have port m_awvalid, output, 1, AXI write-address valid.
REQ-012 SHALL have port m_awready, input, 1, AXI write-address ready.
REQ-013 SHALL have port m_wdata, output, DATA_WIDTH, AXI write data.
REQ-014 SHALL have port m_wstrb, output, DATA_WIDTH/8, byte strobes; all ones.
REQ-015 SHALL have port m_wvalid, output, 1, AXI write-data valid.
REQ-016 SHALL have port m_wready, input, 1, AXI write-data ready.
REQ-017 SHALL have port m_bresp, input, 2, AXI write response.
REQ-018 SHALL have port m_bvalid, input, 1, AXI write-response valid.
REQ-019 SHALL have port m_bready, output, 1, AXI write-response ready.
REQ-020 SHALL have port wr_count, output, 16, number of completed B handshakes; wraps from 16'hFFFF to 0.
REQ-021 SHALL have port busy, output, 1, high in every state other than IDLE.

Function
REQ-022 SHALL implement the FSM states IDLE, FETCH, CAPTURE, ADDR_DATA and RESP.
REQ-023 SHALL, in IDLE with fifo_empty low, assert fifo_rd_en for one cycle and go to FETCH; SHALL NOT read while fifo_empty is high.
REQ-024 SHALL, in FETCH, wait one cycle for the FIFO read latency and go to CAPTURE.
REQ-025 SHALL, in CAPTURE, register fifo_rd_data into m_wdata, then go to ADDR_DATA.
REQ-026 SHALL, on entry to ADDR_DATA, assert m_awvalid and m_wvalid together.
REQ-027 SHALL drop each of m_awvalid and m_wvalid independently on its own handshake (valid and ready both high at a rising edge).
REQ-028 SHALL hold m_awaddr and m_wdata stable while their respective valid signal is high.
REQ-029 SHALL go to RESP once both the AW and W handshakes have completed, in the same cycle or in either order.
REQ-030 SHALL hold m_bready high in RESP; on the m_bvalid handshake it SHALL increment wr_count, advance the address and return to IDLE.
REQ-031 SHALL advance the address by DATA_WIDTH/8 bytes; after word REGION_WORDS-1 the next address SHALL wrap to BASE_ADDR.
REQ-032 SHALL treat a non-OKAY m_bresp (not 2'b00) as completed: no retry, and the address still advances.
REQ-033 SHALL sustain at best one word per 5 cycles when all readys are held high.

Reset
REQ-034 SHALL, on rst_n low at any time including mid-transaction, immediately force state IDLE, all valids, fifo_rd_en and m_bready to 0, m_awaddr to BASE_ADDR, and m_wdata, wr_count and err_count to 0.
REQ-035 SHALL leave m_wstrb constant all-ones, independent of reset.

Configuration
REQ-036 SHALL, with macro AXI_WR_ERR_CNT_EN defined, add output err_count (8 bits, saturating at 8'hFF) that increments on each B handshake with m_bresp != 2'b00.
REQ-037 SHALL, with AXI_WR_ERR_CNT_EN undefined, have no err_count port and no error logic; all other behaviour is identical.

Structure
REQ-038 SHALL place the FSM state encoding, the AXI response constants (OKAY=2'b00, SLVERR=2'b10) and the DATA_WIDTH default in the shared package axi_wr_pkg.
REQ-039 SHALL implement address generation and wrap as the sub-module axi_addr_gen, with inputs advance and rst_n and output addr.

Verification
REQ-040 Bench SHALL cover: one word 128'hFFFE..F0 in the FIFO, all readys high -> one AW at 0x0 with matching wdata, wr_count = 1, busy low again after 5 cycles.
REQ-041 Bench SHALL cover: m_awready held low 3 cycles while m_wready is high -> W completes first, AW completes 3 cycles later, exactly one write results.
REQ-042 Bench SHALL cover: REGION_WORDS = 2 with 3 words sent -> addresses 0x00, 0x10, 0x00.
REQ-043 Bench SHALL cover: m_bresp = 2'b10 on the second of 2 writes -> wr_count = 2, err_count = 1 (macro defined).
REQ-044 Bench SHALL cover: rst_n pulsed low during ADDR_DATA -> valids drop asynchronously, m_awaddr = BASE_ADDR, and the next write is issued at BASE_ADDR.
REQ-045 Bench SHALL cover: fifo_empty held high for 100 cycles -> fifo_rd_en is never asserted and busy stays low.
